// File: rtl/sdram_pkg.sv
// ============================================================================
// Module  : sdram_pkg
// Brief   : Shared SDRAM command encodings and arbiter state encoding.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_arbit.sv
// ============================================================================
// Module  : sdram_arbit
// Brief   : SDRAM command-bus arbiter between init, refresh, write and read.
//           Optional macro SDRAM_ARBIT_RR_EN enables write/read round-robin.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int BA_W   = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              refr_req,
    input  logic              refr_end,
    input  logic [3:0]        refr_cmd,
    input  logic [ADDR_W-1:0] refr_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              refr_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr
);

    state_t state;
    state_t state_nxt;
    logic   pick_wr;

`ifdef SDRAM_ARBIT_RR_EN
    // High when the write module was served last; reset means read went last.
    logic wr_last;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_last <= 1'b0;
        end else if (state == S_ARBIT && state_nxt == S_WRITE) begin
            wr_last <= 1'b1;
        end else if (state == S_ARBIT && state_nxt == S_READ) begin
            wr_last <= 1'b0;
        end
    end

    assign pick_wr = wr_req && (!rd_req || !wr_last);
`else
    assign pick_wr = wr_req;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_end) state_nxt = S_ARBIT;
            S_ARBIT: begin
                if (refr_req)     state_nxt = S_AREF;
                else if (pick_wr) state_nxt = S_WRITE;
                else if (rd_req)  state_nxt = S_READ;
            end
            S_AREF:  if (refr_end) state_nxt = S_ARBIT;
            S_WRITE: if (wr_end)   state_nxt = S_ARBIT;
            S_READ:  if (rd_end)   state_nxt = S_ARBIT;
            default: state_nxt = S_INIT;
        endcase
    end

    assign refr_en = (state == S_AREF);
    assign wr_en   = (state == S_WRITE);
    assign rd_en   = (state == S_READ);

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_ba   = '0;
        sdram_addr = '0;
        case (state)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sdram_cmd  = refr_cmd;
                sdram_addr = refr_addr;
            end
            S_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_ba   = '0;
                sdram_addr = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter ADDR_W, default 12, SDRAM row/column address width.
REQ-002 Parameter BA_W, default 2, SDRAM bank address width.
REQ-003 Clock and reset: one clock, sys_clk; reset sys_rst_n is synchronous and active-low.
REQ-004 sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-005 sys_rst_n  in  1  synchronous active-low reset.
REQ-006 init_end  in  1  init sequence done; level, stays high after first assertion.
REQ-007 init_cmd / init_ba / init_addr  in  4 / BA_W / ADDR_W  init module command bus.
REQ-008 refr_req / refr_end  in  1 / 1  auto-refresh request (level) and completion pulse.
REQ-009 refr_cmd / refr_addr  in  4 / ADDR_W  refresh module command bus; refresh bank address is driven as 0.
REQ-010 wr_req / wr_end, rd_req / rd_end  in  1 each  write and read request (level) and completion pulse.
REQ-011 wr_cmd / wr_ba / wr_addr, rd_cmd / rd_ba / rd_addr  in  4 / BA_W / ADDR_W  write and read command buses.
REQ-012 refr_en / wr_en / rd_en  out  1 each  grant to the refresh, write and read modules; at most one is high.
REQ-013 sdram_cmd  out  4  {cs_n, ras_n, cas_n, we_n} to the device.
REQ-014 sdram_ba / sdram_addr  out  BA_W / ADDR_W  device bank and address.

Function
REQ-015 FSM states: INIT, ARBIT, AREF, WRITE, READ; state is registered and the grants decode combinationally from it (refr_en = AREF, wr_en = WRITE, rd_en = READ).
REQ-016 INIT->ARBIT on the first cycle init_end=1; otherwise the FSM stays in INIT.
REQ-017 Selection in ARBIT, fixed priority: refr_req > wr_req > rd_req; the chosen state is entered the next cycle, so grant latency from ARBIT is 1 cycle.
REQ-018 ARBIT with no request: stay in ARBIT.
REQ-019 AREF->ARBIT on refr_end=1; WRITE->ARBIT on wr_end=1; READ->ARBIT on rd_end=1.
REQ-020 No preemption: a refr_req arriving during WRITE/READ waits for the matching *_end, spends one cycle in ARBIT, then wins.
REQ-021 A *_end pulse from a module that is not granted is ignored.
REQ-022 The FSM spends at least one ARBIT cycle between any two grants, so the grants are never high back-to-back.
REQ-023 The output mux is combinational on state: INIT drives the init bus, AREF the refresh bus, WRITE the write bus, READ the read bus.
REQ-024 In ARBIT, sdram_cmd=4'b0111 (NOP), sdram_ba=0 and sdram_addr=0.
REQ-025 Requests are levels: a requester holds *_req until its *_end, and the arbiter does not latch requests.

Reset
REQ-026 With sys_rst_n=0 at a clock edge: state=INIT, all grants 0, round-robin pointer=0 (read served last), and outputs follow the init bus.
REQ-027 Reset mid-grant aborts immediately, with no wait for *_end; the grant drops in the cycle after the reset edge.

Configuration
REQ-028 With macro SDRAM_ARBIT_RR_EN defined: when wr_req and rd_req are both high in ARBIT without refr_req, the one not served last wins; a 1-bit pointer updates on each WRITE/READ entry; refresh keeps absolute priority.
REQ-029 Without SDRAM_ARBIT_RR_EN: fixed priority per REQ-017, and no pointer register exists.

Structure
REQ-030 Shared package sdram_pkg holds the command encodings NOP=4'b0111, PRE=4'b0010, AREF=4'b0001, ACT, WR and RD, plus the state encoding.
REQ-031 Single module; no sub-module is required, with the output mux kept as a case statement inside the module.

Verification
REQ-032 Reset then init_end=1 at cycle 10 -> state ARBIT at cycle 11 and sdram_cmd=4'b0111.
REQ-033 refr_req and wr_req both high in ARBIT -> refr_en=1 the next cycle; refr_end -> ARBIT; then wr_en=1 one cycle later.
REQ-034 wr_req held, refr_req raised in the 3rd WRITE cycle -> wr_en stays 1 until wr_end, then ARBIT for 1 cycle, then refr_en=1.
REQ-035 With RR_EN, wr_req and rd_req held continuously -> grants alternate W,R,W,R; without RR_EN -> only W.
REQ-036 sys_rst_n=0 during READ with rd_addr=12'h3A5 -> next cycle rd_en=0, state INIT, and sdram_addr equals init_addr.
REQ-037 Stray wr_end pulse while in AREF -> no state change and refr_en stays 1.
